// File: rtl/byte_unstriping.sv
// ============================================================================
// byte_unstriping: merges lane_0/lane_1 byte pairs into one byte stream.
// Optional misalignment flag enabled by defining UNSTRIPE_ERR_EN. Rev 1.0
// ============================================================================
`default_nettype none

module byte_unstriping #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk_2f,
  input  logic         reset,
  input  logic [W-1:0] lane_0,
  input  logic [W-1:0] lane_1,
  input  logic         valid_0,
  input  logic         valid_1,
  output logic         ready,
  output logic [W-1:0] data_out,
  output logic         valid_out,
  output logic         err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT0 = 2'd1,
    EMIT1 = 2'd2
  } state_t;

  logic [W-1:0]   mem0_q [DEPTH];
  logic [W-1:0]   mem1_q [DEPTH];
  logic [DEPTH-1:0] pair_q;

  state_t         state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [W-1:0]   data_out_q, data_out_d;
  logic           valid_out_q, valid_out_d;
  logic           wr_en;
  logic           pop;

  assign ready     = (count_q != FULL);
  assign wr_en     = valid_0 && ready;
  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;

  // Storage needs no reset: count/pointers decide what is live.
  always_ff @(posedge clk_2f) begin
    if (wr_en) begin
      mem0_q[wr_ptr_q] <= lane_0;
      mem1_q[wr_ptr_q] <= lane_1;
      pair_q[wr_ptr_q] <= valid_1;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    pop         = 1'b0;

    // IDLE with a non-empty FIFO emits straight away, giving one-edge latency.
    case (state_q)
      EMIT1: begin
        data_out_d  = mem1_q[rd_ptr_q];
        valid_out_d = 1'b1;
        pop         = 1'b1;
      end
      IDLE, EMIT0: begin
        if (state_q == EMIT0 || count_q != '0) begin
          data_out_d  = mem0_q[rd_ptr_q];
          valid_out_d = 1'b1;
          if (pair_q[rd_ptr_q]) state_d = EMIT1;
          else                  pop     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    count_d  = count_q + CW'(wr_en) - CW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);

    if (pop) state_d = (count_d != '0) ? EMIT0 : IDLE;
  end

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

`ifdef UNSTRIPE_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (valid_1 & ~valid_0);
  end

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_byte_unstriping.sv
// ============================================================================
// tb_byte_unstriping: directed self-checking bench for byte_unstriping. Rev 1.0
// ============================================================================
`default_nettype none

module tb_byte_unstriping;

  logic       clk_2f = 1'b0;
  logic       reset;
  logic [7:0] lane_0, lane_1;
  logic       valid_0, valid_1;
  logic       ready;
  logic [7:0] data_out;
  logic       valid_out;
  logic       err;

  int n_total = 0;
  int n_bad   = 0;

`ifdef UNSTRIPE_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  byte_unstriping #(.DEPTH(4), .W(8)) dut (
    .clk_2f    (clk_2f),
    .reset     (reset),
    .lane_0    (lane_0),
    .lane_1    (lane_1),
    .valid_0   (valid_0),
    .valid_1   (valid_1),
    .ready     (ready),
    .data_out  (data_out),
    .valid_out (valid_out),
    .err       (err)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic drive(input logic [7:0] l0, input logic [7:0] l1, input logic v0, input logic v1);
    lane_0  = l0;
    lane_1  = l1;
    valid_0 = v0;
    valid_1 = v1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  e;
    int  p;
    bit  saw_not_ready;
    bit  gap;
    bit  started;
    bit  ready_low;

    reset = 1'b0;
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    step();
    step();
    check("rst_valid_out", valid_out, 0);
    check("rst_data_out",  data_out,  0);
    check("rst_err",       err,       0);
    check("rst_ready",     ready,     1);
    reset = 1'b1;
    step();

    // ---- single pair ----
    drive(8'hA1, 8'hB2, 1'b1, 1'b1);
    step();
    check("pair_no_bypass", valid_out, 0);
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    step();
    check("pair_b0_valid", valid_out, 1);
    check("pair_b0_data",  data_out,  8'hA1);
    step();
    check("pair_b1_valid", valid_out, 1);
    check("pair_b1_data",  data_out,  8'hB2);
    step();
    check("pair_end_valid", valid_out, 0);
    check("pair_hold_data", data_out,  8'hB2);
    step();
    check("pair_idle_valid", valid_out, 0);

    // ---- odd tail ----
    drive(8'h55, 8'h77, 1'b1, 1'b0);
    step();
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    step();
    check("tail_valid", valid_out, 1);
    check("tail_data",  data_out,  8'h55);
    step();
    check("tail_end_valid", valid_out, 0);
    step();
    check("tail_idle_valid", valid_out, 0);
    check("tail_ready", ready, 1);

    // ---- full / back-pressure: pair offered every cycle, junk while !ready ----
    e = 0;
    p = 0;
    saw_not_ready = 0;
    for (int cyc = 0; cyc < 100 && e < 16; cyc++) begin
      if (valid_out) begin
        check("full_data", data_out, e);
        e++;
      end
      if (!ready) saw_not_ready = 1;
      if (p < 8) begin
        if (ready) begin
          drive(8'(2 * p), 8'(2 * p + 1), 1'b1, 1'b1);
          p++;
        end else begin
          drive(8'hF0, 8'hF1, 1'b1, 1'b1);
        end
      end else begin
        drive(8'h00, 8'h00, 1'b0, 1'b0);
      end
      step();
    end
    check("full_byte_count", e, 16);
    check("full_ready_dropped", saw_not_ready, 1);
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    step();
    check("full_drained_valid", valid_out, 0);
    check("full_drained_ready", ready, 1);

    // ---- sustained half rate: 8 pairs, one every 2 cycles ----
    e = 0;
    p = 0;
    gap = 0;
    started = 0;
    ready_low = 0;
    for (int cyc = 0; cyc < 40 && e < 16; cyc++) begin
      if (!ready) ready_low = 1;
      if (valid_out) begin
        check("half_data", data_out, 32'h10 + e);
        started = 1;
        e++;
      end else if (started) begin
        gap = 1;
      end
      if (p < 8 && (cyc % 2) == 0) begin
        drive(8'(8'h10 + 2 * p), 8'(8'h11 + 2 * p), 1'b1, 1'b1);
        p++;
      end else begin
        drive(8'h00, 8'h00, 1'b0, 1'b0);
      end
      step();
    end
    check("half_byte_count", e, 16);
    check("half_gap", gap, 0);
    check("half_ready_low", ready_low, 0);
    step();
    check("half_end_valid", valid_out, 0);

    // ---- misalignment ----
    drive(8'h00, 8'hEE, 1'b0, 1'b1);
    step();
    check("mis_err", err, EXP_ERR);
    check("mis_valid", valid_out, 0);
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    step();
    check("mis_err_held", err, EXP_ERR);
    check("mis_no_output", valid_out, 0);
    check("mis_ready", ready, 1);

    // ---- reset mid-burst with 3 entries buffered ----
    for (int k = 0; k < 4; k++) begin
      drive(8'(8'h20 + 2 * k), 8'(8'h21 + 2 * k), 1'b1, 1'b1);
      step();
    end
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    check("burst_active", valid_out, 1);
    check("burst_full_not", ready, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_ready", ready, 1);
    check("mid_rst_err",   err,   0);
    step();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("post_rst_no_stale", valid_out, 0);
    end
    check("post_rst_ready", ready, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
